seven_seg_scanner: RTL and testbench
====================================

// Module: seven_seg_scanner
// PURPOSE
//  Parametrised multiplexed 7-segment driver, successor to seven_seg_controller. Scans NUM_DIGITS
//  common-anode digits from a packed hex word, adding per-digit DP, digit enables, leading-zero
//  blanking, PWM brightness and frame-coherent input latching (no tearing). Sits beside top_level
//  debug display, fed with game_state / score / timer words.
// PARAMETERS
//  NUM_DIGITS   8        digits scanned (1..16)
//  SCAN_PERIOD  100_000  clk_in cycles per digit slot (>=4)
//  DIM_BITS     4        brightness_in width; 2**DIM_BITS duty steps
// PORTS
//  clk_in          in   1             system clock (25 MHz pixel clock domain)
//  rst_in          in   1             asynchronous, active-high reset
//  val_in          in   4*NUM_DIGITS  hex nibbles; nibble i -> digit i (digit 0 = rightmost)
//  dp_in           in   NUM_DIGITS    1 = light decimal point of digit i
//  digit_en_in     in   NUM_DIGITS    1 = digit i may be lit; 0 = forced dark
//  lz_blank_in     in   1             1 = blank leading-zero digits
//  brightness_in   in   DIM_BITS      duty code; 0 = dimmest, all-ones = full
//  cat_out         out  7             cathodes {g,f,e,d,c,b,a}, active-low
//  dp_out          out  1             decimal point cathode, active-low
//  an_out          out  NUM_DIGITS    anodes, active-low, at most one low
//  digit_idx_out   out  clog2(NUM_DIGITS) digit currently in slot
//  frame_done_out  out  1             1-cycle pulse when last digit slot ends
// BEHAVIOUR
//  - Counters: tick 0..SCAN_PERIOD-1, digit 0..NUM_DIGITS-1. tick==SCAN_PERIOD-1 -> tick<=0, digit++;
//    digit wraps NUM_DIGITS-1 -> 0 and frame_done_out pulses that cycle.
//  - Shadow latch: val/dp/en/lz/brightness sampled into shadow regs on the wrap cycle and on the
//    first clk_in edge after rst_in deasserts (load_pending flag set by reset). Mid-frame input
//    changes never affect the current frame.
//  - At latch: on_cycles = ((brightness+1)*SCAN_PERIOD) >> DIM_BITS (width clog2(SCAN_PERIOD)+DIM_BITS+1,
//    no overflow); lz mask = digits above highest nonzero nibble when lz set (digit 0 never blanked;
//    all-zero word shows single "0"). DP of a blanked digit is also dark.
//  - Lit condition for slot: digit enabled AND not lz-blanked AND 1 <= tick < on_cycles. tick 0 is a
//    mandatory dark guard cycle (anti-ghosting) even at full brightness.
//  - When lit: an_out = ~(1<<digit); cat_out = ~font(nibble); dp_out = ~dp. Else an_out all ones,
//    cat_out 7'h7F, dp_out 1.
//  - Font: hex table identical to binary_to_seven_seg (0->7'b011_1111, 1->7'b000_0110, 8->7'b111_1111,
//    A->7'b111_0111, F->7'b111_0001).
//  - All outputs registered: outputs reflect counter state with 1-cycle latency; digit_idx_out matches
//    the digit driving an_out/cat_out that same cycle.
//  - Reset (async): tick=0, digit=0, shadows=0, load_pending=1, an_out all ones, cat_out 7'h7F,
//    dp_out 1, digit_idx_out 0, frame_done_out 0. Reset mid-slot kills outputs immediately.
//  - Non-power-of-2 NUM_DIGITS: digit counter wraps at NUM_DIGITS-1, never reaches unused codes.
// TESTING (NUM_DIGITS=4, SCAN_PERIOD=8, DIM_BITS=2 unless noted)
//  1 val=16'h1A3F, en=4'hF, br=3, lz=0 -> per slot: 1 dark guard cycle then 7 lit; digit0 cat=~7'b111_0001,
//    digit3 cat=~7'b000_0110; anodes 1110,1101,1011,0111; frame_done every 32 cycles.
//  2 br=0 -> on_cycles=2: exactly 1 lit cycle per slot (tick 1); br=1 -> ticks 1..3 lit.
//  3 val=16'h0050, lz=1 -> digits 3,2 dark all frame, digits 1,0 show 5,0; val=0 -> only digit0 "0".
//  4 change val 16'h1111->16'h2222 at digit 2 mid-frame -> digits 2,3 still show 1 until frame_done;
//    next frame all 2.
//  5 en=4'b1010, dp=4'b1111 -> digits 0,2 fully dark incl. DP; digits 1,3 dp_out low while lit.
//  6 assert rst_in async mid-slot -> outputs dark same cycle, no clock; release -> first frame uses
//    inputs sampled on first edge, digit 0 scanned first.

Source files
------------

// File: rtl/seven_seg_scanner_if.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner_if
//
// Purpose:
//   Groups the display-side signals of seven_seg_scanner into one bundle.
//   It has two sides. The producer side supplies the packed hex word, the
//   decimal points, the digit enables, leading-zero blanking and brightness.
//   The scanner side returns the multiplexed cathode/anode drive, the digit
//   index and a frame marker.
//
// Signals:
//   val_in          4*NUM_DIGITS  hex nibbles, nibble i -> digit i (digit 0 rightmost)
//   dp_in           NUM_DIGITS    1 = light decimal point of digit i
//   digit_en_in     NUM_DIGITS    1 = digit i may be lit
//   lz_blank_in     1             1 = blank leading-zero digits
//   brightness_in   DIM_BITS      duty code, 0 dimmest, all-ones full
//   cat_out         7             cathodes {g,f,e,d,c,b,a}, active-low
//   dp_out          1             decimal point cathode, active-low
//   an_out          NUM_DIGITS    anodes, active-low, at most one low
//   digit_idx_out   IDX_W         digit currently occupying the slot
//   frame_done_out  1             one-cycle pulse at the end of the last slot
//
// Modports:
//   master  drives the inputs and observes the outputs (display owner / bench)
//   slave   the scanner itself
// ---------------------------------------------------------------------------
interface seven_seg_scanner_if #(
    parameter int NUM_DIGITS = 8,
    parameter int DIM_BITS   = 4
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] val_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en_in;
    logic                    lz_blank_in;
    logic [DIM_BITS-1:0]     brightness_in;

    logic [6:0]              cat_out;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   an_out;
    logic [IDX_W-1:0]        digit_idx_out;
    logic                    frame_done_out;

    modport master (
        output val_in,
        output dp_in,
        output digit_en_in,
        output lz_blank_in,
        output brightness_in,
        input  cat_out,
        input  dp_out,
        input  an_out,
        input  digit_idx_out,
        input  frame_done_out
    );

    modport slave (
        input  val_in,
        input  dp_in,
        input  digit_en_in,
        input  lz_blank_in,
        input  brightness_in,
        output cat_out,
        output dp_out,
        output an_out,
        output digit_idx_out,
        output frame_done_out
    );

endinterface

// File: rtl/seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner
//
// Purpose:
//   Multiplexed driver for NUM_DIGITS common-anode seven-segment digits. Each
//   digit owns a slot of SCAN_PERIOD clocks. The first clock of every slot is
//   always dark, which acts as an anti-ghosting guard. After the guard, the
//   digit stays lit for a brightness-dependent number of clocks.
//
//   All display inputs are captured into shadow registers once per frame,
//   so a frame never shows a mix of old and new values. The capture happens
//   in the last cycle of the last slot, and also on the first clock after
//   reset is released.
//
//   Leading-zero blanking darkens every digit above the most significant
//   nonzero nibble. Digit 0 is never blanked, so an all-zero word still
//   shows a single "0".
//
// Ports:
//   clk_in   system clock
//   rst_in   asynchronous, active-high reset
//   bus      seven_seg_scanner_if.slave (inputs val/dp/en/lz/brightness,
//            outputs cat/dp/an/digit_idx/frame_done, all registered)
//
// Parameters:
//   NUM_DIGITS   digits scanned (1..16)
//   SCAN_PERIOD  clocks per digit slot (>= 4)
//   DIM_BITS     brightness code width
// ---------------------------------------------------------------------------
module seven_seg_scanner #(
    parameter int NUM_DIGITS  = 8,
    parameter int SCAN_PERIOD = 100_000,
    parameter int DIM_BITS    = 4
) (
    input logic                clk_in,
    input logic                rst_in,
    seven_seg_scanner_if.slave bus
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TICK_W = $clog2(SCAN_PERIOD);
    localparam int ON_W   = TICK_W + DIM_BITS + 1;

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(SCAN_PERIOD - 1);
    localparam logic [IDX_W-1:0]  DIGIT_LAST = IDX_W'(NUM_DIGITS - 1);

    // Hex font, segment order {g,f,e,d,c,b,a}, active-high here.
    function automatic logic [6:0] segFont(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = 7'b011_1111;
            4'h1: seg = 7'b000_0110;
            4'h2: seg = 7'b101_1011;
            4'h3: seg = 7'b100_1111;
            4'h4: seg = 7'b110_0110;
            4'h5: seg = 7'b110_1101;
            4'h6: seg = 7'b111_1101;
            4'h7: seg = 7'b000_0111;
            4'h8: seg = 7'b111_1111;
            4'h9: seg = 7'b110_1111;
            4'hA: seg = 7'b111_0111;
            4'hB: seg = 7'b111_1100;
            4'hC: seg = 7'b011_1001;
            4'hD: seg = 7'b101_1110;
            4'hE: seg = 7'b111_1001;
            default: seg = 7'b111_0001;
        endcase
        return seg;
    endfunction

    // Scan counters
    logic [TICK_W-1:0]       tick_q, tick_d;
    logic [IDX_W-1:0]        digit_q, digit_d;
    logic                    slotEnd;
    logic                    frameEnd;

    // Frame shadow state
    logic                    loadPending_q;
    logic                    loadShadow;
    logic [4*NUM_DIGITS-1:0] shVal_q;
    logic [NUM_DIGITS-1:0]   shDp_q;
    logic [NUM_DIGITS-1:0]   shEn_q;
    logic [NUM_DIGITS-1:0]   shBlank_q, shBlank_d;
    logic [ON_W-1:0]         onCycles_q, onCycles_d;
    logic [ON_W-1:0]         onProduct;
    logic [IDX_W-1:0]        highNonZero;

    // Output registers and their next values
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              cat_q, cat_d;
    logic                    dpOut_q, dpOut_d;
    logic [IDX_W-1:0]        idx_q;
    logic                    frameDone_q;
    logic [3:0]              nibble;
    logic                    lit;

    // Slot/frame counters. The digit counter advances only when a slot ends.
    // It wraps explicitly at NUM_DIGITS-1, so unused codes are never reached
    // when NUM_DIGITS is not a power of two.
    always_comb begin
        slotEnd  = (tick_q == TICK_LAST);
        frameEnd = slotEnd && (digit_q == DIGIT_LAST);
        tick_d   = slotEnd ? '0 : tick_q + 1'b1;
        digit_d  = digit_q;
        if (slotEnd) begin
            digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
        end
        loadShadow = frameEnd || loadPending_q;
    end

    // Values captured into the shadow registers.
    // The lit length is (brightness+1)*SCAN_PERIOD / 2**DIM_BITS. ON_W has one
    // spare bit, so this product cannot overflow. The blank mask covers every
    // digit above the highest nonzero nibble; for an all-zero word that is
    // every digit except digit 0.
    always_comb begin
        onProduct  = (ON_W'(bus.brightness_in) + ON_W'(1)) * ON_W'(SCAN_PERIOD);
        onCycles_d = onProduct >> DIM_BITS;

        highNonZero = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bus.val_in[4*i +: 4] != 4'h0) begin
                highNonZero = IDX_W'(i);
            end
        end

        shBlank_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            shBlank_d[i] = bus.lz_blank_in && (IDX_W'(i) > highNonZero);
        end
    end

    // Drive for the current counter position, built only from shadow state.
    // Tick 0 is never lit, even at full brightness.
    always_comb begin
        nibble = shVal_q[4*int'(digit_q) +: 4];
        lit    = shEn_q[digit_q] && !shBlank_q[digit_q] &&
                 (tick_q != '0) && (ON_W'(tick_q) < onCycles_q);

        an_d    = '1;
        cat_d   = 7'h7F;
        dpOut_d = 1'b1;
        if (lit) begin
            an_d    = ~(NUM_DIGITS'(1) << digit_q);
            cat_d   = ~segFont(nibble);
            dpOut_d = ~shDp_q[digit_q];
        end
    end

    // Sequential state. The output registers use the async reset, so
    // asserting reset mid-slot darkens the display at once without
    // waiting for a clock.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tick_q        <= '0;
            digit_q       <= '0;
            loadPending_q <= 1'b1;
            shVal_q       <= '0;
            shDp_q        <= '0;
            shEn_q        <= '0;
            shBlank_q     <= '0;
            onCycles_q    <= '0;
            an_q          <= '1;
            cat_q         <= 7'h7F;
            dpOut_q       <= 1'b1;
            idx_q         <= '0;
            frameDone_q   <= 1'b0;
        end else begin
            tick_q        <= tick_d;
            digit_q       <= digit_d;
            loadPending_q <= 1'b0;
            if (loadShadow) begin
                shVal_q    <= bus.val_in;
                shDp_q     <= bus.dp_in;
                shEn_q     <= bus.digit_en_in;
                shBlank_q  <= shBlank_d;
                onCycles_q <= onCycles_d;
            end
            an_q        <= an_d;
            cat_q       <= cat_d;
            dpOut_q     <= dpOut_d;
            idx_q       <= digit_q;
            frameDone_q <= frameEnd;
        end
    end

    assign bus.an_out         = an_q;
    assign bus.cat_out        = cat_q;
    assign bus.dp_out         = dpOut_q;
    assign bus.digit_idx_out  = idx_q;
    assign bus.frame_done_out = frameDone_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scanner
//
// Bench for seven_seg_scanner with 4 digits, 8-clock slots and 2-bit
// brightness. The reference model never uses counters. It works from the
// absolute position p, the number of clock edges since reset release
// minus one. From p it derives the slot, the tick and the frame with
// plain division. Each frame is shown from a snapshot of the inputs
// captured at the frame boundary.
// ---------------------------------------------------------------------------
module tb_seven_seg_scanner;

    localparam int ND    = 4;
    localparam int SP    = 8;
    localparam int DB    = 2;
    localparam int FRAME = ND * SP;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;

    seven_seg_scanner_if #(.NUM_DIGITS(ND), .DIM_BITS(DB)) bus ();

    seven_seg_scanner #(
        .NUM_DIGITS (ND),
        .SCAN_PERIOD(SP),
        .DIM_BITS   (DB)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Font reference, active-high {g,f,e,d,c,b,a}
    logic [6:0] fontTable [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Inputs currently driven
    logic [15:0] curVal;
    logic [3:0]  curDp, curEn;
    logic        curLz;
    logic [1:0]  curBr;

    // Snapshot used by the model for the frame on display
    logic [15:0] snapVal;
    logic [3:0]  snapDp, snapEn;
    logic        snapLz;
    logic [1:0]  snapBr;
    int          edgeCount;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] v, input logic [3:0] dp,
                                 input logic [3:0] en, input logic lz, input logic [1:0] br);
        curVal = v; curDp = dp; curEn = en; curLz = lz; curBr = br;
        bus.val_in        = v;
        bus.dp_in         = dp;
        bus.digit_en_in   = en;
        bus.lz_blank_in   = lz;
        bus.brightness_in = br;
    endtask

    task automatic modelReset();
        edgeCount = 0;
        snapVal = '0; snapDp = '0; snapEn = '0; snapLz = 1'b0; snapBr = '0;
    endtask

    // Waits one clock edge, then compares every output with the model.
    task automatic stepAndCheck();
        int p, d, t, sig, onCyc, anExp, catExp, dpExp;
        bit lit;
        logic [3:0] nib;
        @(posedge clk_in);
        #1;
        p = edgeCount;
        edgeCount++;
        d = (p / SP) % ND;
        t = p % SP;

        sig = 1;
        for (int i = 0; i < ND; i++) begin
            if (((snapVal >> (4*i)) & 16'hF) != 0) sig = i + 1;
        end
        onCyc = ((int'(snapBr) + 1) * SP) / (1 << DB);
        lit = snapEn[d] && !(snapLz && d >= sig) && t >= 1 && t < onCyc;
        nib = 4'((snapVal >> (4*d)) & 16'hF);

        anExp  = lit ? (4'hF ^ (1 << d)) : 4'hF;
        catExp = lit ? (7'h7F ^ fontTable[nib]) : 7'h7F;
        dpExp  = lit ? (snapDp[d] ? 0 : 1) : 1;

        checkOutput("an_out",         32'(bus.an_out),         32'(anExp));
        checkOutput("cat_out",        32'(bus.cat_out),        32'(catExp));
        checkOutput("dp_out",         32'(bus.dp_out),         32'(dpExp));
        checkOutput("digit_idx_out",  32'(bus.digit_idx_out),  32'(d));
        checkOutput("frame_done_out", 32'(bus.frame_done_out), (p % FRAME == FRAME - 1) ? 32'd1 : 32'd0);

        if (p == 0 || (p % FRAME) == FRAME - 1) begin
            snapVal = curVal; snapDp = curDp; snapEn = curEn; snapLz = curLz; snapBr = curBr;
        end
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) stepAndCheck();
    endtask

    // With probability 1/prob per cycle, the inputs change at the falling
    // edge, so changes land mid-frame.
    task automatic runRandom(input int n, input int prob);
        logic [31:0] r;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            if ($urandom_range(0, prob - 1) == 0) begin
                r = $urandom;
                applyStimulus(r[15:0] >> $urandom_range(0, 16), 4'($urandom), 4'($urandom),
                              1'($urandom), 2'($urandom));
            end
            stepAndCheck();
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " an_out"},         32'(bus.an_out),         32'hF);
        checkOutput({tag, " cat_out"},        32'(bus.cat_out),        32'h7F);
        checkOutput({tag, " dp_out"},         32'(bus.dp_out),         32'h1);
        checkOutput({tag, " digit_idx_out"},  32'(bus.digit_idx_out),  32'h0);
        checkOutput({tag, " frame_done_out"}, 32'(bus.frame_done_out), 32'h0);
    endtask

    initial begin
        applyStimulus(16'h1A3F, 4'h0, 4'hF, 1'b0, 2'd3);
        modelReset();
        repeat (2) @(posedge clk_in);
        #1;
        checkResetOutputs("reset");

        // Full brightness, all digits, no blanking
        @(negedge clk_in);
        rst_in = 1'b0;
        runCycles(3 * FRAME);

        // Dimmest, then one step up, changed mid-frame
        @(negedge clk_in);
        applyStimulus(16'h1A3F, 4'h0, 4'hF, 1'b0, 2'd0);
        runCycles(2 * FRAME + 5);
        @(negedge clk_in);
        applyStimulus(16'h1A3F, 4'h0, 4'hF, 1'b0, 2'd1);
        runCycles(2 * FRAME);

        // Leading-zero blanking, including the all-zero word
        @(negedge clk_in);
        applyStimulus(16'h0050, 4'h0, 4'hF, 1'b1, 2'd3);
        runCycles(2 * FRAME);
        @(negedge clk_in);
        applyStimulus(16'h0000, 4'hF, 4'hF, 1'b1, 2'd3);
        runCycles(2 * FRAME);

        // Value change mid-frame, while digit 2 is in its slot
        @(negedge clk_in);
        applyStimulus(16'h1111, 4'h0, 4'hF, 1'b0, 2'd3);
        runCycles(FRAME - (edgeCount % FRAME) + 2 * SP + 3);
        @(negedge clk_in);
        applyStimulus(16'h2222, 4'h0, 4'hF, 1'b0, 2'd3);
        runCycles(2 * FRAME);

        // Digit enables with every decimal point requested
        @(negedge clk_in);
        applyStimulus(16'h89AB, 4'hF, 4'b1010, 1'b0, 2'd3);
        runCycles(2 * FRAME);

        // Asynchronous reset while a digit is lit
        @(negedge clk_in);
        rst_in = 1'b1;
        applyStimulus(16'h1A3F, 4'h5, 4'hF, 1'b0, 2'd3);
        @(negedge clk_in);
        rst_in = 1'b0;
        modelReset();
        runCycles(5);
        #2;
        rst_in = 1'b1;
        #1;
        checkResetOutputs("async reset");
        @(negedge clk_in);
        applyStimulus(16'h4C2E, 4'h9, 4'hF, 1'b0, 2'd2);
        @(negedge clk_in);
        rst_in = 1'b0;
        modelReset();
        runCycles(2 * FRAME);

        // Random inputs with frequent mid-frame changes
        runRandom(40 * FRAME, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
